// File: rtl/complex_acc.sv
// Complex dot-product accumulator: captures the multiplier's product a fixed delay after each
// data_start, sums LEN captures with saturation and strobes the result out.
module complex_acc #(
    parameter int unsigned IN_W        = 8,
    parameter int unsigned ACC_W       = 12,
    parameter int unsigned LEN         = 4,
    parameter int unsigned CAPTURE_DLY = 7
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    data_start,
    input  logic                    acc_clr,
    input  logic signed [IN_W-1:0]  product_real,
    input  logic signed [IN_W-1:0]  product_image,
    output logic signed [ACC_W-1:0] acc_real,
    output logic signed [ACC_W-1:0] acc_image,
    output logic                    acc_valid,
    output logic                    busy,
    output logic                    overflow
);

    localparam logic signed [ACC_W-1:0] AccMax  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]              LastCnt = 8'(LEN - 1);
    localparam logic [3:0]              DlyLoad = 4'(CAPTURE_DLY - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              dly_q, dly_d;
    logic [7:0]              cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] out_r_q, out_r_d;
    logic signed [ACC_W-1:0] out_i_q, out_i_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    valid_q, valid_d;

    logic [ACC_W:0]          sum_r, sum_i;
    logic                    clamp_r, clamp_i;
    logic signed [ACC_W-1:0] sat_r, sat_i;
    logic                    capture;

    // One guard bit above ACC_W; a disagreement with the MSB means the sum left the range.
    always_comb begin
        sum_r   = {acc_r_q[ACC_W-1], acc_r_q}
                + {{(ACC_W+1-IN_W){product_real[IN_W-1]}}, product_real};
        sum_i   = {acc_i_q[ACC_W-1], acc_i_q}
                + {{(ACC_W+1-IN_W){product_image[IN_W-1]}}, product_image};
        clamp_r = sum_r[ACC_W] ^ sum_r[ACC_W-1];
        clamp_i = sum_i[ACC_W] ^ sum_i[ACC_W-1];
        sat_r   = clamp_r ? (sum_r[ACC_W] ? AccMin : AccMax) : sum_r[ACC_W-1:0];
        sat_i   = clamp_i ? (sum_i[ACC_W] ? AccMin : AccMax) : sum_i[ACC_W-1:0];
    end

    assign capture = (state_q == StWait) && (dly_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        cnt_d     = cnt_q;
        acc_r_d   = acc_r_q;
        acc_i_d   = acc_i_q;
        ovf_d     = ovf_q;
        out_r_d   = out_r_q;
        out_i_d   = out_i_q;
        out_ovf_d = out_ovf_q;
        valid_d   = 1'b0;

        if (capture) begin
            if (acc_clr) begin
                // Clear wins over the capture: the product is dropped with the partial sum.
                acc_r_d = '0;
                acc_i_d = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end else if (cnt_q == LastCnt) begin
                out_r_d   = sat_r;
                out_i_d   = sat_i;
                out_ovf_d = ovf_q | clamp_r | clamp_i;
                valid_d   = 1'b1;
                acc_r_d   = '0;
                acc_i_d   = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end else begin
                acc_r_d = sat_r;
                acc_i_d = sat_i;
                cnt_d   = cnt_q + 8'd1;
                ovf_d   = ovf_q | clamp_r | clamp_i;
            end
            if (data_start) begin
                state_d = StWait;
                dly_d   = DlyLoad;
            end else begin
                state_d = StIdle;
            end
        end else begin
            if (acc_clr) begin
                acc_r_d = '0;
                acc_i_d = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
            // A start while waiting restarts the upstream, so the pending capture is abandoned.
            if (data_start) begin
                state_d = StWait;
                dly_d   = DlyLoad;
            end else if (state_q == StWait) begin
                dly_d = dly_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            dly_q     <= '0;
            cnt_q     <= '0;
            acc_r_q   <= '0;
            acc_i_q   <= '0;
            ovf_q     <= 1'b0;
            out_r_q   <= '0;
            out_i_q   <= '0;
            out_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            cnt_q     <= cnt_d;
            acc_r_q   <= acc_r_d;
            acc_i_q   <= acc_i_d;
            ovf_q     <= ovf_d;
            out_r_q   <= out_r_d;
            out_i_q   <= out_i_d;
            out_ovf_q <= out_ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign acc_real  = out_r_q;
    assign acc_image = out_i_q;
    assign overflow  = out_ovf_q;
    assign acc_valid = valid_q;
    assign busy      = (state_q == StWait);

endmodule
